// File: rtl/dmem_lsu_mem.sv
// Byte-addressable little-endian data memory with RISC-V sub-word loads/stores,
// req/ready handshake and WAIT_STATES wait cycles. Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/W/D.
module dmem_lsu_mem #(
    parameter int BYTE_SIZE   = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [2:0]             funct3,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [BYTE_SIZE*8-1:0] wd,
    output logic [BYTE_SIZE*8-1:0] rd,
    output logic                   busy,
    output logic                   ready,
    output logic                   err
);
    localparam int IW = $clog2(DEPTH_BYTES);
    localparam int DW = BYTE_SIZE * 8;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    // Only the in-memory byte index is kept; higher address bits alias by wrap.
    typedef struct packed {
        logic          we;
        logic [2:0]    funct3;
        logic [IW-1:0] idx;
        logic [DW-1:0] wd;
    } req_t;

    state_t                    state, state_nx;
    req_t                      q;
    logic [3:0]                cnt;
    logic [7:0]                mem [DEPTH_BYTES];
    logic [3:0]                nbytes;
    logic                      illegal, misalign, fault;
    logic [BYTE_SIZE-1:0][7:0] raw;
    logic [DW-1:0]             ld;
    logic                      msb;
    logic                      unused_addr_hi;

    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IW];

    assign nbytes  = 4'd1 << q.funct3[1:0];
    assign illegal = (q.funct3 == 3'b111) ||
                     (BYTE_SIZE == 4 && (q.funct3 == 3'b011 || q.funct3 == 3'b110));
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (q.idx[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
`else
    assign misalign = 1'b0;
`endif
    assign fault = illegal | misalign;

    // Per-lane read byte at (addr + k) mod DEPTH_BYTES.
    for (genvar k = 0; k < BYTE_SIZE; k++) begin : g_lane
        logic [IW-1:0] lidx;
        assign lidx   = q.idx + IW'(k);
        assign raw[k] = mem[lidx];
    end

    always_comb begin
        msb = 1'b0;
        ld  = '0;
        for (int k = 0; k < BYTE_SIZE; k++)
            if (4'(k) + 4'd1 == nbytes) msb = raw[k][7];
        for (int k = 0; k < BYTE_SIZE; k++)
            ld[8*k +: 8] = (4'(k) < nbytes) ? raw[k] : {8{msb & ~q.funct3[2]}};
    end

    always_ff @(posedge clk) begin
        if (state == ACCESS && q.we && !fault) begin
            for (int k = 0; k < BYTE_SIZE; k++)
                if (4'(k) < nbytes) mem[q.idx + IW'(k)] <= q.wd[8*k +: 8];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (cnt == 4'd0) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            rd    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                q.we     <= we;
                q.funct3 <= funct3;
                q.idx    <= addr[IW-1:0];
                q.wd     <= wd;
                cnt      <= 4'(WAIT_STATES - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS) begin
                err <= fault;
                if (!fault && !q.we) rd <= ld;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign ready = (state == RESP);
endmodule

// File: tb/tb_dmem_lsu_mem.sv
// Bench for dmem_lsu_mem: directed vector table, reset abort, latency/back-to-back
// timing on WAIT_STATES=0/2 instances, and random traffic against a byte-array model.
module tb_dmem_lsu_mem;
    logic clk, rst_n;

    logic        req3, we3, busy3, ready3, err3;
    logic [2:0]  f3_3;
    logic [31:0] addr3, wd3, rd3;

    logic        req_l, we_l;
    logic [2:0]  f3_l;
    logic [31:0] addr_l, wd_l;
    logic        busy0, ready0, err0, busy2, ready2, err2;
    logic [31:0] rd0, rd2;

    dmem_lsu_mem #(.WAIT_STATES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .funct3(f3_3), .addr(addr3),
        .wd(wd3), .rd(rd3), .busy(busy3), .ready(ready3), .err(err3));
    dmem_lsu_mem #(.WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req_l), .we(we_l), .funct3(f3_l), .addr(addr_l),
        .wd(wd_l), .rd(rd0), .busy(busy0), .ready(ready0), .err(err0));
    dmem_lsu_mem #(.WAIT_STATES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req(req_l), .we(we_l), .funct3(f3_l), .addr(addr_l),
        .wd(wd_l), .rd(rd2), .busy(busy2), .ready(ready2), .err(err2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: plain byte array plus the architecturally visible rd/err.
    logic [7:0]  mem_m [256];
    logic [31:0] rd_m;
    logic        err_m;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic model_txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d);
        int nb;
        bit bad;
        longint unsigned v;
        nb  = 1 << f[1:0];
        bad = (f == 3'd7) || (f == 3'd3) || (f == 3'd6);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((a % nb) != 0) bad = 1'b1;
`endif
        if (bad) begin
            err_m = 1'b1;
        end else begin
            err_m = 1'b0;
            if (w) begin
                for (int k = 0; k < nb; k++) mem_m[(a + k) % 256] = 8'(d >> (8 * k));
            end else begin
                v = 0;
                for (int k = 0; k < nb; k++)
                    v += longint'(mem_m[(a + k) % 256]) << (8 * k);
                if (!f[2] && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
                rd_m = v[31:0];
            end
        end
    endtask

    task automatic txn3(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output logic e);
        int n;
        @(negedge clk);
        req3 = 1'b1; we3 = w; f3_3 = f; addr3 = a; wd3 = d;
        @(negedge clk);
        req3 = 1'b0;
        n = 0;
        while (!ready3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready3) begin
            n_tot++;
            $display("FAIL txn_timeout: no ready within 50 cycles, addr 0x%0h", a);
        end
        r = rd3;
        e = err3;
        model_txn(w, f, a, d);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int first0, first2, cnt0, cnt2;
        int last0, last2, idle0, idle2, pul0, pul2, bad0, bad2;

        rst_n = 1'b0;
        req3 = 0; we3 = 0; f3_3 = 0; addr3 = 0; wd3 = 0;
        req_l = 0; we_l = 0; f3_l = 0; addr_l = 0; wd_l = 0;
        rd_m = 0; err_m = 0;
        repeat (2) @(negedge clk);
        chk("rst_rd", rd3, 0);
        chk("rst_busy", busy3, 0);
        chk("rst_ready", ready3, 0);
        chk("rst_err", err3, 0);
        rst_n = 1'b1;

        for (int a = 0; a < 256; a += 4) txn3(1'b1, 3'd2, a, $urandom, r, e);

        tbl.push_back('{1'b1, 3'd2, 32'h10, 32'h01020304, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h20, 32'h8899AABB, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h21, 32'h0,        32'hFFFFFFAA, 1'b0});
        tbl.push_back('{1'b0, 3'd4, 32'h21, 32'h0,        32'h000000AA, 1'b0});
        tbl.push_back('{1'b0, 3'd1, 32'h22, 32'h0,        32'hFFFF8899, 1'b0});
        tbl.push_back('{1'b0, 3'd5, 32'h22, 32'h0,        32'h00008899, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h40, 32'h0,        32'h00008899, 1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h40, 32'h12345677, 32'h00008899, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h40, 32'h0,        32'h00000077, 1'b0});
        tbl.push_back('{1'b1, 3'd1, 32'h42, 32'h0000ABCD, 32'h00000077, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h40, 32'h0,        32'hABCD0077, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h50, 32'hCAFEF00D, 32'hABCD0077, 1'b0});
        tbl.push_back('{1'b1, 3'd7, 32'h50, 32'h11111111, 32'hABCD0077, 1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'h50, 32'h0,        32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b0, 3'd3, 32'h50, 32'h0,        32'hCAFEF00D, 1'b1});
        tbl.push_back('{1'b0, 3'd6, 32'h50, 32'h0,        32'hCAFEF00D, 1'b1});
`ifdef DMEM_MISALIGN_TRAP_EN
        tbl.push_back('{1'b0, 3'd2, 32'h41, 32'h0,        32'hCAFEF00D, 1'b1});
        tbl.push_back('{1'b1, 3'd1, 32'h43, 32'h00005555, 32'hCAFEF00D, 1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'h40, 32'h0,        32'hABCD0077, 1'b0});
`else
        tbl.push_back('{1'b1, 3'd2, 32'hFE, 32'h11223344, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b0, 3'd4, 32'hFE, 32'h0,        32'h00000044, 1'b0});
        tbl.push_back('{1'b0, 3'd4, 32'hFF, 32'h0,        32'h00000033, 1'b0});
        tbl.push_back('{1'b0, 3'd4, 32'h00, 32'h0,        32'h00000022, 1'b0});
        tbl.push_back('{1'b0, 3'd4, 32'h01, 32'h0,        32'h00000011, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'hFE, 32'h0,        32'h11223344, 1'b0});
        tbl.push_back('{1'b0, 3'd1, 32'h41, 32'h0,        32'hFFFFCD00, 1'b0});
`endif
        foreach (tbl[i]) begin
            txn3(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, r, e);
            chk($sformatf("vec%0d_rd", i), r, tbl[i].rd);
            chk($sformatf("vec%0d_err", i), e, tbl[i].err);
        end

        // Reset in the second wait cycle must abort the store.
        @(negedge clk);
        req3 = 1'b1; we3 = 1'b1; f3_3 = 3'd2; addr3 = 32'h10; wd3 = 32'hDEADBEEF;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", busy3, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rd", rd3, 0);
        chk("abort_busy", busy3, 0);
        chk("abort_ready", ready3, 0);
        chk("abort_err", err3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_m = 0; err_m = 0;
        txn3(1'b0, 3'd2, 32'h10, 32'h0, r, e);
        chk("abort_lw", r, 32'h01020304);

        // Latency: store through WAIT_STATES=0 and =2 instances side by side.
        @(negedge clk);
        req_l = 1'b1; we_l = 1'b1; f3_l = 3'd2; addr_l = 32'h0; wd_l = 32'h5A5A1234;
        @(negedge clk);
        req_l = 1'b0;
        first0 = 0; first2 = 0; cnt0 = 0; cnt2 = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) @(negedge clk);
            if (ready0) begin cnt0++; if (first0 == 0) first0 = i; end
            if (ready2) begin cnt2++; if (first2 == 0) first2 = i; end
        end
        chk("lat_w0_cycle", first0, 2);
        chk("lat_w2_cycle", first2, 4);
        chk("lat_w0_pulses", cnt0, 1);
        chk("lat_w2_pulses", cnt2, 1);

        // Back-to-back loads with req held high: one idle cycle between pulses.
        @(negedge clk);
        req_l = 1'b1; we_l = 1'b0;
        last0 = -1; last2 = -1; idle0 = 0; idle2 = 0; pul0 = 0; pul2 = 0; bad0 = 0; bad2 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy0) idle0++;
            if (!busy2) idle2++;
            if (ready0) begin
                if (last0 >= 0 && (i - last0 != 3 || idle0 != 1)) bad0++;
                last0 = i; idle0 = 0; pul0++;
            end
            if (ready2) begin
                if (last2 >= 0 && (i - last2 != 5 || idle2 != 1)) bad2++;
                last2 = i; idle2 = 0; pul2++;
            end
        end
        req_l = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_w0_spacing_errs", bad0, 0);
        chk("b2b_w2_spacing_errs", bad2, 0);
        chk("b2b_w0_pulses", pul0, 10);
        chk("b2b_w2_pulses", pul2, 6);
        chk("b2b_w0_rd", rd0, 32'h5A5A1234);
        chk("b2b_w2_rd", rd2, 32'h5A5A1234);
        chk("b2b_err", {err0, err2}, 2'b00);
        chk("b2b_idle", {busy0, busy2}, 2'b00);

        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic [2:0]  f;
            logic [31:0] a, d;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            d = $urandom;
            txn3(w, f, a, d, r, e);
            chk($sformatf("rnd%0d_rd(we=%0d f3=%0d a=0x%0h)", i, w, f, a), r, rd_m);
            chk($sformatf("rnd%0d_err(we=%0d f3=%0d a=0x%0h)", i, w, f, a), e, err_m);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dmem_lsu_mem.md
Name: dmem_lsu_mem

Overview:
- Parametrised, byte-addressable, little-endian data memory for the next multicycle/pipelined core.
- Supports RISC-V sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3.
- Uses a req/ready handshake with programmable wait states, so the core can model slower memory.
- Registered read data; unaligned and illegal-size access detection.

Parameters:
- BYTE_SIZE, 4: data word width in bytes (4 = 32-bit core); must be 4 or 8.
- ADDR_WIDTH, 32: address bus width.
- DEPTH_BYTES, 256: memory size in bytes; power of two.
- WAIT_STATES, 1: extra cycles between request acceptance and access; 0..15.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 1: access request; sampled only while not busy.
- we, input, 1: 1 = store, 0 = load.
- funct3, input, 3: access size/sign (000 B, 001 H, 010 W, 011 D when BYTE_SIZE=8, 100 BU, 101 HU, 110 WU when BYTE_SIZE=8).
- addr, input, ADDR_WIDTH: byte address.
- wd, input, BYTE_SIZE*8: store data, right-aligned (only the low bytes are used for sub-word stores).
- rd, output, BYTE_SIZE*8: load data, right-aligned and sign/zero-extended; registered.
- busy, output, 1: request in progress; req ignored while high.
- ready, output, 1: one-cycle pulse marking completion; rd/err valid that cycle.
- err, output, 1: access faulted (misaligned or illegal funct3); valid with ready.

Behaviour:
- Reset (async, rst_n=0):
  - rd=0, busy=0, ready=0, err=0, FSM=IDLE.
  - Memory array is not cleared.
  - Reset during WAIT/ACCESS aborts the access; no byte is written.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - On req=1, latch we/funct3/addr/wd and set busy=1 next cycle.
  - Go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: counter loaded with WAIT_STATES-1, decrements each cycle; go to ACCESS at 0.
- ACCESS (one cycle):
  - If the access is illegal: set err=1, perform no write, leave rd unchanged.
  - Else, store: write the size's bytes at addr+k (k = 0..size-1) at the clock edge; other bytes are untouched.
  - Else, load: assemble bytes little-endian, extend per funct3, register into rd.
  - Go to RESP.
- RESP: ready=1 and busy=1 for exactly this cycle; next cycle busy=0, ready=0, state IDLE.
  - err holds its value until the next request's ACCESS cycle.
  - A new req is accepted in the cycle after RESP at the earliest.
- Latency: req accepted at edge N; ready high in cycle N+WAIT_STATES+2.
- Address wrap: effective byte index = (addr+k) mod DEPTH_BYTES. Accesses straddling the top wrap to byte 0.
- rd changes only in the ACCESS cycle of a legal load; stores and faults do not disturb rd.
- Illegal funct3 (111; 011/110 when BYTE_SIZE=4) always gives err=1 and no side effect.
- req held high continuously produces back-to-back transactions separated by one idle cycle.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]!=0, word with addr[1:0]!=0, or doubleword with addr[2:0]!=0 is misaligned.
  - A misaligned access gives err=1 with no write and no rd update.
- Undefined:
  - Misaligned accesses complete normally byte-by-byte at addr+k with wrap.
  - err is asserted only for illegal funct3.

Test Plan:
- Reset mid-WAIT (WAIT_STATES=3, SW addr 0x10 wd 0xDEADBEEF, rst_n low in 2nd wait cycle) -> outputs 0; subsequent LW 0x10 returns the prior content, not 0xDEADBEEF.
- SW 0x20 wd 0x8899AABB, then LB 0x21 -> rd=0xFFFFFFAA; LBU 0x21 -> 0x000000AA; LH 0x22 -> 0xFFFF8899; LHU 0x22 -> 0x00008899.
- SB 0x40 wd 0x12345677 over word 0x00000000 -> LW 0x40 = 0x00000077; SH 0x42 wd 0xABCD -> LW 0x40 = 0xABCD0077.
- WAIT_STATES=0 and 2: req at edge N -> ready pulse exactly in cycle N+2 and N+4 respectively; req held high -> one idle cycle between ready pulses.
- With DMEM_MISALIGN_TRAP_EN, LW 0x41 -> err=1, rd unchanged. Without it, SW 0xFE wd 0x11223344 -> bytes 0xFE=44, 0xFF=33, 0x00=22, 0x01=11 (wrap, DEPTH_BYTES=256), err=0.
- funct3=111 store to 0x50 -> err=1; LW 0x50 afterwards shows the original data unchanged.
